pulse_interval_meter: RTL and testbench
=======================================

// Module: pulse_interval_meter
// PURPOSE
//  Receive-side checker for periodic timing strobes such as the 1us/3us ticks from the counter block.
//  Measures the clock-cycle interval between successive strobe rising edges.
//  Checks each interval against a nominal value and declares lock after N good intervals in a row.
//  Sits downstream of any tick generator as a health monitor and for bench self-checking.
// PARAMETERS
//  CNT_W     8   width of interval counter and period output
//  NOMINAL   20  expected interval in clk cycles (1us at 20MHz)
//  TOL       1   allowed +/- deviation from NOMINAL, inclusive
//  LOCK_N    3   consecutive in-range intervals needed to lock
//  TIMEOUT   40  cycles without an edge before dropping to IDLE; must be > NOMINAL+TOL and < 2**CNT_W
// PORTS
//  clk         in   1      system clock
//  rst         in   1      synchronous reset, active-high
//  strobe_in   in   1      tick under test, pulse or level, synchronous to clk
//  period      out  CNT_W  last measured interval in cycles
//  period_vld  out  1      1-cycle pulse: period updated
//  err         out  1      1-cycle pulse: measured interval out of range
//  timeout     out  1      1-cycle pulse: no edge for TIMEOUT cycles
//  locked      out  1      high while state==LOCKED
//  err_cnt     out  8      saturating count of err pulses, cleared only by rst
// BEHAVIOUR
//  Clock and reset: one clk domain; rst is synchronous and active-high.
//  Reset values: all outputs 0, state=IDLE, cnt=0, good=0, edge register s_d=0.
//  Edge detection: rise = strobe_in & ~s_d, with s_d <= strobe_in every cycle.
//   A level held high counts as exactly one edge.
//  Interval counter cnt:
//   on rise, cnt <= 1;
//   otherwise, if state != IDLE, cnt <= cnt+1.
//   So with rises at cycles t and t+20, cnt == 20 at the second rise.
//  States:
//   IDLE: first rise -> HUNT. Start cnt; no period_vld on this edge.
//   HUNT / LOCKED, on rise:
//    period <= cnt and period_vld <= 1 on the next edge (latency 1 cycle after rise).
//    In range (NOMINAL-TOL <= cnt <= NOMINAL+TOL): good <= good+1.
//     HUNT -> LOCKED when good+1 == LOCK_N.
//    Out of range: err <= 1, err_cnt += 1 (saturate at 255), good <= 0.
//     LOCKED -> HUNT.
//   Timeout, in HUNT or LOCKED with no rise and cnt == TIMEOUT:
//    timeout <= 1, state <= IDLE, good <= 0, cnt <= 0.
//    period holds its last value.
//  locked is a registered output: it goes high on the same edge that enters LOCKED.
//  Simultaneous rise and cnt == TIMEOUT: the rise wins and is measured as an interval.
//   That interval is out of range, so err pulses and there is no timeout.
//  cnt never exceeds TIMEOUT, so no wrap-around is possible.
//  rst mid-measurement: state returns to IDLE, and the first edge after reset is not measured.
//  period_vld, err and timeout are never high for more than one cycle each.
// STRUCTURE
//  Header timing_defs.vh holds:
//   state encodings ST_IDLE=2'd0, ST_HUNT=2'd1, ST_LOCKED=2'd2;
//   NOMINAL/TOL defaults shared with the tick generator.
//  Sub-module rise_detect (clk, rst, d, rise) holds the s_d register and the edge AND.
//  Everything else lives in a single always block plus registered outputs.
// TESTING (clk 50ns, default parameters)
//  1. rst, then 1-cycle strobe every 20 cycles x5 -> four period_vld with period=20.
//     locked rises on the edge after the 3rd measured interval; err=0.
//  2. While locked, one 23-cycle gap -> period=23, err pulse, err_cnt=1, locked=0.
//     Then 3 more 20-cycle gaps -> locked=1 again.
//  3. Gaps of 19, 21 then 18 -> first two in range; 18 gives err and resets good to 0.
//  4. Strobe stops after lock -> timeout pulse 40 cycles after last rise, locked=0.
//     Next rise gives no period_vld; the one after gives period_vld.
//  5. strobe_in held high 5 cycles per period of 20 -> period=20, exactly one edge per tick.
//  6. rst asserted mid-interval in LOCKED -> next cycle all outputs 0, err_cnt=0.
//     First rise after reset gives no period_vld.

Source files
------------

// File: rtl/pulse_interval_meter_pkg.sv
// pulse_interval_meter_pkg: shared state encoding, tick timing defaults and helpers
package pulse_interval_meter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;
  localparam int NOMINAL_DEF = 20;
  localparam int TOL_DEF = 1;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/pulse_interval_meter_rise_detect.sv
// pulse_interval_meter_rise_detect: one-cycle rising-edge pulse from a synchronous level
module pulse_interval_meter_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic s_q;
  always_ff @(posedge clk) s_q <= rst ? 1'b0 : d;
  assign rise = d & ~s_q;
endmodule

// File: rtl/pulse_interval_meter.sv
// pulse_interval_meter: measures strobe rise-to-rise intervals, flags errors/timeouts and declares lock
module pulse_interval_meter
  import pulse_interval_meter_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int NOMINAL = NOMINAL_DEF,
  parameter int TOL     = TOL_DEF,
  parameter int LOCK_N  = 3,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe_in,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             err,
  output logic             timeout,
  output logic             locked,
  output logic [7:0]       err_cnt
);
  localparam int GOOD_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] LO_C = CNT_W'(NOMINAL - TOL);
  localparam logic [CNT_W-1:0] HI_C = CNT_W'(NOMINAL + TOL);
  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] LOCK_G = GOOD_W'(LOCK_N);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic vld_q, vld_d, err_q, err_d, to_q, to_d, locked_q;
  logic rise, in_range;
  pulse_interval_meter_rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (strobe_in),
    .rise (rise)
  );
  assign in_range = (cnt_q >= LO_C) && (cnt_q <= HI_C);
  assign good_inc = good_q + 1'b1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    good_d = good_q;
    period_d = period_q;
    err_cnt_d = err_cnt_q;
    vld_d = 1'b0;
    err_d = 1'b0;
    to_d = 1'b0;
    if (rise) begin
      cnt_d = CNT_W'(1);
      if (state_q == ST_IDLE) state_d = ST_HUNT;
      else begin
        period_d = cnt_q;
        vld_d = 1'b1;
        if (in_range) begin
          good_d = (good_q == LOCK_G) ? good_q : good_inc;
          state_d = (good_inc == LOCK_G) ? ST_LOCKED : state_q;
        end else begin
          err_d = 1'b1;
          err_cnt_d = sat_inc8(err_cnt_q);
          good_d = '0;
          state_d = ST_HUNT;
        end
      end
    end else if (state_q != ST_IDLE) begin
      // the counter stops at TIMEOUT, so it can never wrap
      if (cnt_q == TO_C) begin
        to_d = 1'b1;
        state_d = ST_IDLE;
        good_d = '0;
        cnt_d = '0;
      end else cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      good_q <= '0;
      period_q <= '0;
      err_cnt_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      to_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      good_q <= good_d;
      period_q <= period_d;
      err_cnt_q <= err_cnt_d;
      vld_q <= vld_d;
      err_q <= err_d;
      to_q <= to_d;
      locked_q <= state_d == ST_LOCKED;
    end
  end
  assign period = period_q;
  assign period_vld = vld_q;
  assign err = err_q;
  assign timeout = to_q;
  assign locked = locked_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_pulse_interval_meter.sv
// tb_pulse_interval_meter: vector table, corner sequences and random strobes against an interval model
module tb_pulse_interval_meter;
  localparam int NOM = 20, TOL = 1, LOCK_N = 3, TMO = 40;
  logic clk = 1'b0, rst = 1'b1, strobe_in = 1'b0;
  logic [7:0] period, err_cnt;
  logic period_vld, err, timeout, locked;
  int total = 0, bad = 0;
  pulse_interval_meter dut (
    .clk(clk), .rst(rst), .strobe_in(strobe_in), .period(period),
    .period_vld(period_vld), .err(err), .timeout(timeout), .locked(locked), .err_cnt(err_cnt)
  );
  always #25 clk = ~clk;
  int m_cyc = 0, m_last = 0, m_good = 0, m_per = 0, m_ec = 0;
  bit m_prev = 0, m_act = 0, m_vld = 0, m_err = 0, m_to = 0, m_lock = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", nm, m_cyc, act, exp);
    end
  endtask
  // reference works in absolute cycle numbers: interval = now - time of last rise
  task automatic model(input bit s, input bit r);
    bit rise;
    int iv;
    rise = s && !m_prev;
    iv = m_cyc - m_last;
    if (r) begin
      m_prev = 0; m_act = 0; m_good = 0; m_per = 0; m_ec = 0;
      m_vld = 0; m_err = 0; m_to = 0; m_lock = 0;
    end else begin
      m_prev = s; m_vld = 0; m_err = 0; m_to = 0;
      if (rise) begin
        if (m_act) begin
          m_per = iv;
          m_vld = 1;
          if (iv >= NOM - TOL && iv <= NOM + TOL) begin
            m_good++;
            if (m_good >= LOCK_N) m_lock = 1;
          end else begin
            m_err = 1;
            if (m_ec < 255) m_ec++;
            m_good = 0;
            m_lock = 0;
          end
        end
        m_act = 1;
        m_last = m_cyc;
      end else if (m_act && iv == TMO) begin
        m_to = 1; m_act = 0; m_good = 0; m_lock = 0;
      end
    end
    m_cyc++;
  endtask
  task automatic step(input bit s, input bit r);
    @(negedge clk);
    strobe_in = s;
    rst = r;
    @(posedge clk);
    model(s, r);
    #1;
    chk("period", period, m_per);
    chk("period_vld", period_vld, m_vld);
    chk("err", err, m_err);
    chk("timeout", timeout, m_to);
    chk("locked", locked, m_lock);
    chk("err_cnt", err_cnt, m_ec);
  endtask
  typedef struct {
    int hi;
    int gap;
    logic vld;
    int per;
    logic err;
    logic lock;
    int ec;
  } vec_t;
  vec_t tbl[16];
  initial begin
    tbl[0]  = '{1, 20, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 20, 1, 20, 0, 0, 0};
    tbl[2]  = '{1, 20, 1, 20, 0, 0, 0};
    tbl[3]  = '{1, 20, 1, 20, 0, 1, 0};
    tbl[4]  = '{1, 23, 1, 20, 0, 1, 0};
    tbl[5]  = '{1, 20, 1, 23, 1, 0, 1};
    tbl[6]  = '{1, 20, 1, 20, 0, 0, 1};
    tbl[7]  = '{1, 20, 1, 20, 0, 0, 1};
    tbl[8]  = '{1, 19, 1, 20, 0, 1, 1};
    tbl[9]  = '{1, 21, 1, 19, 0, 1, 1};
    tbl[10] = '{1, 18, 1, 21, 0, 1, 1};
    tbl[11] = '{1, 20, 1, 18, 1, 0, 2};
    tbl[12] = '{5, 20, 1, 20, 0, 0, 2};
    tbl[13] = '{5, 20, 1, 20, 0, 0, 2};
    tbl[14] = '{5, 20, 1, 20, 0, 1, 2};
    tbl[15] = '{5, 20, 1, 20, 0, 1, 2};
    step(0, 1);
    step(0, 1);
    chk("rst_period", period, 0);
    chk("rst_locked", locked, 0);
    for (int k = 0; k < 16; k++) begin
      step(1, 0);
      chk($sformatf("tbl%0d_vld", k), period_vld, tbl[k].vld);
      chk($sformatf("tbl%0d_period", k), period, tbl[k].per);
      chk($sformatf("tbl%0d_err", k), err, tbl[k].err);
      chk($sformatf("tbl%0d_locked", k), locked, tbl[k].lock);
      chk($sformatf("tbl%0d_err_cnt", k), err_cnt, tbl[k].ec);
      for (int i = 1; i < tbl[k].gap; i++) step(i < tbl[k].hi, 0);
    end
    for (int i = 20; i <= 40; i++) begin
      step(0, 0);
      chk("to_pulse", timeout, i == 40);
    end
    chk("to_unlocked", locked, 0);
    chk("to_period_hold", period, 20);
    step(1, 0);
    chk("after_to_no_vld", period_vld, 0);
    for (int i = 1; i < 20; i++) step(0, 0);
    step(1, 0);
    chk("after_to_vld", period_vld, 1);
    chk("after_to_period", period, 20);
    for (int i = 1; i < 40; i++) step(0, 0);
    step(1, 0);
    chk("edge_at_to_period", period, 40);
    chk("edge_at_to_err", err, 1);
    chk("edge_at_to_no_timeout", timeout, 0);
    chk("edge_at_to_err_cnt", err_cnt, 3);
    for (int k = 0; k < 3; k++) begin
      for (int i = 1; i < 20; i++) step(0, 0);
      step(1, 0);
    end
    chk("relock", locked, 1);
    for (int i = 0; i < 7; i++) step(0, 0);
    step(0, 1);
    chk("midrst_locked", locked, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_period", period, 0);
    step(1, 0);
    chk("midrst_first_no_vld", period_vld, 0);
    for (int i = 1; i < 20; i++) step(0, 0);
    step(1, 0);
    chk("midrst_second_vld", period_vld, 1);
    step(0, 1);
    for (int i = 0; i < 600; i++) step(i % 2 == 0, 0);
    chk("err_cnt_saturated", err_cnt, 255);
    step(0, 1);
    for (int k = 0; k < 150; k++) begin
      int g, h;
      g = ($urandom_range(0, 9) < 7) ? $urandom_range(18, 22) : $urandom_range(2, 45);
      h = $urandom_range(1, (g > 6) ? 6 : g - 1);
      for (int i = 0; i < g; i++) step(i < h, $urandom_range(0, 499) == 0);
    end
    for (int i = 0; i < 45; i++) step(0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
